// File: rtl/dmem_wbuf_responder.sv
// D-memory responder: data array, 1-cycle loads with byte forwarding,
// and a coalescing FIFO write buffer that drains in idle cycles.
module dmem_wbuf_responder #(
  parameter int ADDR_W   = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ceb_i,
  input  logic                          web_i,
  input  logic [ADDR_W-1:0]             a_i,
  input  logic [3:0]                    mask_i,
  input  logic [31:0]                   d_i,
  output logic [31:0]                   q_o,
  output logic                          stall_o,
  output logic [$clog2(WB_DEPTH+1)-1:0] wb_count_o,
  output logic                          wb_empty_o
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = $clog2(WB_DEPTH+1);

  logic [31:0]       mem [2**ADDR_W];

  logic [WB_DEPTH-1:0] vld;
  logic [ADDR_W-1:0] addr [WB_DEPTH];
  logic [3:0]        bm   [WB_DEPTH];
  logic [31:0]       dat  [WB_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              is_load, is_store, full;
  logic              alloc, merge, drain;
  logic [31:0]       wmask, fmask;

  logic [31:0]       rd_data, fwd_data;
  logic [3:0]        fwd_mask;

  // Coalescing keeps addresses unique, so at most one entry matches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (vld[i] && addr[i] == a_i) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign is_load  = !ceb_i && web_i;
  assign is_store = !ceb_i && !web_i && (mask_i != 4'b0);
  assign full     = (count == CNT_W'(WB_DEPTH));
  assign merge    = is_store && hit;
  assign alloc    = is_store && !hit && !full;
  assign stall_o  = is_store && !hit && full;
  assign drain    = ceb_i && (count != '0);

  assign wmask = {{8{mask_i[3]}}, {8{mask_i[2]}},
                  {8{mask_i[1]}}, {8{mask_i[0]}}};
  assign fmask = {{8{fwd_mask[3]}}, {8{fwd_mask[2]}},
                  {8{fwd_mask[1]}}, {8{fwd_mask[0]}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        addr[i] <= '0;
        bm[i]   <= '0;
        dat[i]  <= '0;
      end
    end else begin
      if (merge) begin
        bm[hit_idx]  <= bm[hit_idx] | mask_i;
        dat[hit_idx] <= (dat[hit_idx] & ~wmask) | (d_i & wmask);
      end
      if (alloc) begin
        vld[tail]  <= 1'b1;
        addr[tail] <= a_i;
        bm[tail]   <= mask_i;
        dat[tail]  <= d_i & wmask;
        tail       <= tail + 1'b1;
        count      <= count + 1'b1;
      end
      if (drain) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
        count     <= count - 1'b1;
      end
    end
  end

  // Load path registers only update on loads, so q_o holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      fwd_data <= '0;
      fwd_mask <= '0;
    end else if (is_load) begin
      rd_data  <= mem[a_i];
      fwd_mask <= hit ? bm[hit_idx] : 4'b0;
      fwd_data <= hit ? dat[hit_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (bm[head][b])
          mem[addr[head]][8*b +: 8] <= dat[head][8*b +: 8];
      end
    end
  end

  assign q_o        = (fwd_data & fmask) | (rd_data & ~fmask);
  assign wb_count_o = count;
  assign wb_empty_o = (count == '0);

endmodule
